// File: rtl/avalon_rsa_batch.sv
// avalon_rsa_batch: batch sequencer for an RSA core behind an Avalon-MM master.
// Each job is three WORDS-word operands followed by a WORDS-word result slot.
// For every job the operands are streamed from memory into the core, the core
// is kicked, and the result is streamed back to memory.
// Optional feature: define AVALON_RSA_BATCH_IRQ_EN to add a sticky irq output
// with an irq_clear input; without it those two ports do not exist.
module avalon_rsa_batch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8,
    parameter int WORDS  = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef AVALON_RSA_BATCH_IRQ_EN
    output logic                     irq,
    input  logic                     irq_clear,
`endif
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [CNT_W-1:0]         job_count,
    output logic                     busy,
    output logic                     done,
    input  logic                     avm_m0_waitrequest,
    output logic [ADDR_W-1:0]        avm_m0_address,
    output logic                     avm_m0_read,
    output logic                     avm_m0_write,
    input  logic [DATA_W-1:0]        avm_m0_readdata,
    output logic [DATA_W-1:0]        avm_m0_writedata,
    output logic                     core_we,
    output logic                     core_oe,
    output logic                     core_start,
    output logic [1:0]               core_reg_sel,
    output logic [$clog2(WORDS)-1:0] core_addr,
    output logic [DATA_W-1:0]        core_data_i,
    input  logic [DATA_W-1:0]        core_data_o,
    input  logic                     core_ready
);

    localparam int                IDX_W    = $clog2(WORDS);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(DATA_W / 8);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(4 * WORDS * (DATA_W / 8));
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        START,
        WAIT,
        WRITE,
        NEXT
    } state_t;

    typedef enum logic [1:0] {
        OP0,
        OP1,
        OP2
    } op_t;

    state_t            state;
    op_t               op;
    logic [ADDR_W-1:0] job_base;
    logic [CNT_W-1:0]  remaining;
    logic [IDX_W-1:0]  word_idx;
    logic              wait_armed;
    logic              bus_accept;

    assign bus_accept = ~avm_m0_waitrequest;

    // Batch sequencer: owns the state, the job bookkeeping and every registered output.
    // Operands and result of a job sit back to back, so the bus address simply
    // keeps stepping from the first operand word through the last result word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            op             <= OP0;
            job_base       <= '0;
            remaining      <= '0;
            word_idx       <= '0;
            wait_armed     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            avm_m0_address <= '0;
            avm_m0_read    <= 1'b0;
            avm_m0_write   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        job_base       <= base_addr;
                        remaining      <= job_count;
                        avm_m0_address <= base_addr;
                        word_idx       <= '0;
                        op             <= OP0;
                        busy           <= 1'b1;
                        if (job_count == '0) begin
                            state <= NEXT;
                        end else begin
                            state       <= READ;
                            avm_m0_read <= 1'b1;
                        end
                    end
                end

                READ: begin
                    if (bus_accept) begin
                        avm_m0_address <= avm_m0_address + STEP;
                        word_idx       <= word_idx + IDX_ONE;
                        if (word_idx == LAST_IDX) begin
                            case (op)
                                OP0: op <= OP1;
                                OP1: op <= OP2;
                                default: begin
                                    avm_m0_read <= 1'b0;
                                    state       <= START;
                                end
                            endcase
                        end
                    end
                end

                START: begin
                    wait_armed <= 1'b0;
                    state      <= WAIT;
                end

                WAIT: begin
                    if (!wait_armed) begin
                        wait_armed <= 1'b1;
                    end else if (core_ready) begin
                        avm_m0_write <= 1'b1;
                        state        <= WRITE;
                    end
                end

                WRITE: begin
                    if (bus_accept) begin
                        avm_m0_address <= avm_m0_address + STEP;
                        word_idx       <= word_idx + IDX_ONE;
                        if (word_idx == LAST_IDX) begin
                            avm_m0_write <= 1'b0;
                            state        <= NEXT;
                        end
                    end
                end

                NEXT: begin
                    if (remaining <= CNT_ONE) begin
                        remaining <= '0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        remaining      <= remaining - CNT_ONE;
                        job_base       <= job_base + STRIDE;
                        avm_m0_address <= job_base + STRIDE;
                        word_idx       <= '0;
                        op             <= OP0;
                        avm_m0_read    <= 1'b1;
                        state          <= READ;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Core-side strobes follow the bus handshake in the same cycle, so a stalled
    // read never writes the core and result data passes straight to the bus.
    always_comb begin
        core_we          = 1'b0;
        core_oe          = 1'b0;
        core_start       = 1'b0;
        core_reg_sel     = 2'b00;
        core_addr        = '0;
        core_data_i      = '0;
        avm_m0_writedata = '0;
        case (state)
            READ: begin
                core_addr = word_idx;
                if (bus_accept) begin
                    core_we     = 1'b1;
                    core_data_i = avm_m0_readdata;
                    case (op)
                        OP0:     core_reg_sel = 2'b10;
                        OP1:     core_reg_sel = 2'b11;
                        default: core_reg_sel = 2'b01;
                    endcase
                end
            end
            START: begin
                core_start = 1'b1;
            end
            WRITE: begin
                core_oe          = 1'b1;
                core_addr        = word_idx;
                avm_m0_writedata = core_data_o;
            end
            default: begin
                core_we = 1'b0;
            end
        endcase
    end

`ifdef AVALON_RSA_BATCH_IRQ_EN
    // Sticky completion interrupt; a finishing batch wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (done) begin
            irq <= 1'b1;
        end else if (irq_clear) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_avalon_rsa_batch.sv
// tb_avalon_rsa_batch: drives avalon_rsa_batch (WORDS=4, DATA_W=8) against a
// byte memory slave with random stalls and a toy core, and compares the bus
// traffic and written results with the job layout computed from memory.
`timescale 1ns/1ps
module tb_avalon_rsa_batch;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;
    localparam int WORDS  = 4;
    localparam int CNT_W  = 16;
    localparam int STRIDE = 4 * WORDS;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  job_count;
    logic              busy;
    logic              done;
    logic              avm_m0_waitrequest = 1'b0;
    logic [ADDR_W-1:0] avm_m0_address;
    logic              avm_m0_read;
    logic              avm_m0_write;
    logic [DATA_W-1:0] avm_m0_readdata = '0;
    logic [DATA_W-1:0] avm_m0_writedata;
    logic              core_we;
    logic              core_oe;
    logic              core_start;
    logic [1:0]        core_reg_sel;
    logic [1:0]        core_addr;
    logic [DATA_W-1:0] core_data_i;
    logic [DATA_W-1:0] core_data_o;
    logic              core_ready = 1'b1;
`ifdef AVALON_RSA_BATCH_IRQ_EN
    logic              irq;
    logic              irq_clear;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0]  mem [0:511];
    logic [7:0]  core_ops [0:2][0:3];
    logic [7:0]  core_res [0:3];
    int          core_delay = 0;

    logic [31:0] rd_q[$];
    logic [31:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    int          starts, dones, done_cyc, last_wr_cyc, start_cyc;
    int          overlap, hold_viol, we_viol;
    int          wait_pct = 0;
    logic [31:0] stall_addr = '0;
    int          stall_left = 0;
    logic [31:0] watch_addr = '0;
    int          watch_cycles, watch_we;
    logic        prev_pending = 1'b0;
    logic        prev_rd, prev_wr;
    logic [31:0] prev_addr;

    avalon_rsa_batch #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .WORDS (WORDS),
        .CNT_W (CNT_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
`ifdef AVALON_RSA_BATCH_IRQ_EN
        .irq               (irq),
        .irq_clear         (irq_clear),
`endif
        .start             (start),
        .base_addr         (base_addr),
        .job_count         (job_count),
        .busy              (busy),
        .done              (done),
        .avm_m0_waitrequest(avm_m0_waitrequest),
        .avm_m0_address    (avm_m0_address),
        .avm_m0_read       (avm_m0_read),
        .avm_m0_write      (avm_m0_write),
        .avm_m0_readdata   (avm_m0_readdata),
        .avm_m0_writedata  (avm_m0_writedata),
        .core_we           (core_we),
        .core_oe           (core_oe),
        .core_start        (core_start),
        .core_reg_sel      (core_reg_sel),
        .core_addr         (core_addr),
        .core_data_i       (core_data_i),
        .core_data_o       (core_data_o),
        .core_ready        (core_ready)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to order done against the last accepted write
    always @(posedge clk) cyc <= cyc + 1;

    // Toy core result port
    assign core_data_o = core_res[core_addr];

    // Toy core function: each result byte mixes the three operand bytes asymmetrically
    function automatic logic [7:0] ref_result(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] b2;
        b2 = {b[6:0], 1'b0};
        return (a ^ b2) + c;
    endfunction

    // Memory slave, core model and protocol monitor, evaluated mid-cycle
    always @(negedge clk) begin
        logic w;
        if (reset) begin
            prev_pending       = 1'b0;
            avm_m0_waitrequest = 1'b0;
        end else begin
            w = 1'b0;
            if (avm_m0_read && avm_m0_address == stall_addr && stall_left > 0) begin
                w = 1'b1;
                stall_left--;
            end else if ((avm_m0_read || avm_m0_write) && $urandom_range(99) < wait_pct) begin
                w = 1'b1;
            end
            avm_m0_waitrequest = w;
            avm_m0_readdata    = avm_m0_read ? mem[avm_m0_address[8:0]] : 8'($urandom);
            if (avm_m0_read && avm_m0_write) overlap++;
            if (prev_pending && (avm_m0_read !== prev_rd || avm_m0_write !== prev_wr || avm_m0_address !== prev_addr))
                hold_viol++;
            prev_pending = (avm_m0_read || avm_m0_write) && w;
            prev_rd      = avm_m0_read;
            prev_wr      = avm_m0_write;
            prev_addr    = avm_m0_address;
            if (avm_m0_read && avm_m0_address == watch_addr) watch_cycles++;
            if (avm_m0_read && !w) rd_q.push_back(avm_m0_address);
            if (avm_m0_write && !w) begin
                wr_addr_q.push_back(avm_m0_address);
                wr_data_q.push_back(avm_m0_writedata);
                mem[avm_m0_address[8:0]] = avm_m0_writedata;
                last_wr_cyc = cyc;
            end
            if (core_start) begin
                starts++;
                for (int i = 0; i < 4; i++)
                    core_res[i] = ref_result(core_ops[0][i], core_ops[1][i], core_ops[2][i]);
                core_ready = 1'b0;
                core_delay = $urandom_range(3);
            end else if (!core_ready) begin
                if (core_delay == 0) core_ready = 1'b1;
                else core_delay--;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            #1;
            if (core_we !== (avm_m0_read && !w)) we_viol++;
            if (core_we) begin
                if (avm_m0_address == watch_addr) watch_we++;
                case (core_reg_sel)
                    2'b10:   core_ops[0][core_addr] = core_data_i;
                    2'b11:   core_ops[1][core_addr] = core_data_i;
                    2'b01:   core_ops[2][core_addr] = core_data_i;
                    default: we_viol++;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearMonitor();
        rd_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        starts       = 0;
        dones        = 0;
        done_cyc     = 0;
        last_wr_cyc  = 0;
        overlap      = 0;
        hold_viol    = 0;
        we_viol      = 0;
        watch_cycles = 0;
        watch_we     = 0;
    endtask

    task automatic applyStimulus(input logic [31:0] base, input int count);
        start     = 1'b1;
        base_addr = base;
        job_count = CNT_W'(count);
        start_cyc = cyc;
        tick();
        start     = 1'b0;
        base_addr = $urandom;
        job_count = CNT_W'($urandom);
        checkOutput("busy_after_start", busy, 1);
    endtask

    task automatic waitDone(input int limit);
        int n = 0;
        while (dones == 0 && n < limit) begin
            tick();
            n++;
        end
        checkOutput("done_seen", dones != 0, 1);
        repeat (8) tick();
    endtask

    task automatic checkBatch(input logic [31:0] base, input int count);
        logic [31:0] jb, a, p0, p1, p2;
        logic [7:0]  exp_d;
        int          idx;
        checkOutput("read_count", rd_q.size(), count * 12);
        checkOutput("write_count", wr_addr_q.size(), count * 4);
        for (int j = 0; j < count; j++) begin
            jb = base + 32'(j * STRIDE);
            for (int k = 0; k < 12; k++) begin
                idx = j * 12 + k;
                a   = jb + 32'(k);
                if (idx < rd_q.size()) checkOutput("read_addr", rd_q[idx], a);
            end
            for (int i = 0; i < WORDS; i++) begin
                idx   = j * 4 + i;
                a     = jb + 32'(12 + i);
                p0    = jb + 32'(i);
                p1    = jb + 32'(4 + i);
                p2    = jb + 32'(8 + i);
                exp_d = ref_result(mem[p0[8:0]], mem[p1[8:0]], mem[p2[8:0]]);
                if (idx < wr_addr_q.size()) begin
                    checkOutput("write_addr", wr_addr_q[idx], a);
                    checkOutput("write_data", wr_data_q[idx], exp_d);
                end
            end
        end
        checkOutput("core_starts", starts, count);
        checkOutput("done_pulses", dones, 1);
        if (count > 0) checkOutput("done_after_last_write", done_cyc > last_wr_cyc, 1);
        checkOutput("read_write_overlap", overlap, 0);
        checkOutput("stall_hold", hold_viol, 0);
        checkOutput("core_we_handshake", we_viol, 0);
        checkOutput("busy_idle", busy, 0);
        checkOutput("read_idle", avm_m0_read, 0);
        checkOutput("write_idle", avm_m0_write, 0);
    endtask

    initial begin
        logic [31:0] rb;
        int          rc;
        int          n;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        job_count = '0;
`ifdef AVALON_RSA_BATCH_IRQ_EN
        irq_clear = 1'b0;
`endif
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) core_res[i] = 8'h00;
        clearMonitor();
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_address", avm_m0_address, 0);
        checkOutput("rst_read", avm_m0_read, 0);
        checkOutput("rst_write", avm_m0_write, 0);
        checkOutput("rst_core_we", core_we, 0);
        checkOutput("rst_core_oe", core_oe, 0);
        checkOutput("rst_core_start", core_start, 0);
        checkOutput("rst_reg_sel", core_reg_sel, 0);
`ifdef AVALON_RSA_BATCH_IRQ_EN
        checkOutput("rst_irq", irq, 0);
`endif
        reset = 1'b0;
        tick();

        $display("[TB] single job at 0x100, no stalls");
        clearMonitor();
        wait_pct = 0;
        applyStimulus(32'h100, 1);
        waitDone(400);
        checkBatch(32'h100, 1);
`ifdef AVALON_RSA_BATCH_IRQ_EN
        checkOutput("irq_set", irq, 1);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        checkOutput("irq_cleared", irq, 0);
`endif

        $display("[TB] two jobs at 0x000");
        clearMonitor();
        applyStimulus(32'h000, 2);
        waitDone(600);
        checkBatch(32'h000, 2);

        $display("[TB] stall read word 5 for 3 cycles");
        clearMonitor();
        watch_addr = 32'h105;
        stall_addr = 32'h105;
        stall_left = 3;
        applyStimulus(32'h100, 1);
        waitDone(400);
        checkBatch(32'h100, 1);
        checkOutput("stall_read_cycles", watch_cycles, 4);
        checkOutput("stall_core_we", watch_we, 1);
        watch_addr = 32'hFFFF_0000;
        stall_left = 0;

        $display("[TB] empty batch");
        clearMonitor();
        applyStimulus(32'h080, 0);
        waitDone(50);
        checkOutput("zero_done_latency", done_cyc - start_cyc, 2);
        checkOutput("zero_reads", rd_q.size(), 0);
        checkOutput("zero_writes", wr_addr_q.size(), 0);
        checkOutput("zero_done_pulses", dones, 1);

        $display("[TB] reset during result word 2");
        clearMonitor();
        applyStimulus(32'h040, 1);
        n = 0;
        while (!(avm_m0_write && avm_m0_address == 32'h04E) && n < 400) begin
            tick();
            n++;
        end
        checkOutput("reached_write_word2", avm_m0_write && avm_m0_address == 32'h04E, 1);
        reset = 1'b1;
        tick();
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_address", avm_m0_address, 0);
        checkOutput("mid_rst_read", avm_m0_read, 0);
        checkOutput("mid_rst_write", avm_m0_write, 0);
        checkOutput("mid_rst_core_oe", core_oe, 0);
        checkOutput("mid_rst_core_addr", core_addr, 0);
        checkOutput("mid_rst_writedata", avm_m0_writedata, 0);
        reset = 1'b0;
        clearMonitor();
        repeat (6) tick();
        checkOutput("no_resume_reads", rd_q.size(), 0);
        checkOutput("no_resume_writes", wr_addr_q.size(), 0);
        clearMonitor();
        applyStimulus(32'h0C0, 1);
        waitDone(400);
        checkBatch(32'h0C0, 1);

        $display("[TB] start while busy is ignored");
        clearMonitor();
        wait_pct = 20;
        applyStimulus(32'h180, 2);
        repeat (5) tick();
        start     = 1'b1;
        base_addr = 32'h000;
        job_count = 16'd3;
        tick();
        start = 1'b0;
        waitDone(800);
        checkBatch(32'h180, 2);

        $display("[TB] address wrap");
        clearMonitor();
        applyStimulus(32'hFFFF_FFF4, 2);
        waitDone(800);
        checkBatch(32'hFFFF_FFF4, 2);

        $display("[TB] random batches");
        wait_pct = 30;
        for (int t = 0; t < 6; t++) begin
            rb = 32'($urandom_range(511));
            rc = $urandom_range(1, 3);
            clearMonitor();
            applyStimulus(rb, rc);
            waitDone(1000);
            checkBatch(rb, rc);
        end

`ifdef AVALON_RSA_BATCH_IRQ_EN
        $display("[TB] done and irq_clear together");
        wait_pct  = 0;
        clearMonitor();
        irq_clear = 1'b1;
        applyStimulus(32'h000, 0);
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        checkOutput("irq_done_seen", done, 1);
        tick();
        checkOutput("irq_set_priority", irq, 1);
        irq_clear = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
